hilo_seq: RTL and testbench
===========================

Name: hilo_seq

Overview:
- Multicycle sequencer directly upstream and downstream of the combinational signed divider (and multiplier) in the ALU.
- Latches operands into registers that drive the divider's dividend/divisor inputs, then waits a programmable number of cycles for the deep combinational path to settle.
- Captures the 64-bit {remainder, quotient} result into the architectural HI/LO registers and signals completion.
- Also services move-to-HI/LO writes and flags division by zero.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO register width.
- LATENCY, 4, settle cycles allowed for the combinational unit; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request a new operation; sampled only in IDLE.
- op_a  in  DATA_WIDTH  dividend / multiplicand.
- op_b  in  DATA_WIDTH  divisor / multiplier.
- q_out  out  DATA_WIDTH  registered op_a, driven to the divider dividend input.
- m_out  out  DATA_WIDTH  registered op_b, driven to the divider divisor input.
- z_in  in  2*DATA_WIDTH  {remainder, quotient} from the combinational unit.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  DATA_WIDTH  move-to data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- hi  out  DATA_WIDTH  HI register (remainder).
- lo  out  DATA_WIDTH  LO register (quotient).
- dz  out  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Reset (clr_n low, asynchronous) forces:
  - state = IDLE; q_out, m_out, hi, lo = 0; busy, done, dz = 0; counter = 0.
  - Reset mid-operation aborts with no HI/LO update and no done pulse.
- States: IDLE and WAIT. busy = (state == WAIT), combinational from the state register.
- IDLE:
  - On an edge with start=1: q_out <= op_a, m_out <= op_b, cnt <= LATENCY-1, dz <= 0, state <= WAIT.
- WAIT:
  - On each edge with cnt != 0: cnt <= cnt-1.
  - On the edge with cnt == 0:
    - hi <= z_in[2*DATA_WIDTH-1:DATA_WIDTH], lo <= z_in[DATA_WIDTH-1:0].
    - dz <= (m_out == 0); done <= 1; state <= IDLE.
- Latency: start sampled at edge N, so done is high during the cycle after edge N+LATENCY.
- LATENCY=1 gives WAIT for exactly one cycle.
- done is registered and high for exactly one cycle; it is cleared on the next edge unconditionally.
- start asserted while busy is ignored; there is no queueing.
- start sampled in the same cycle done is high is accepted, giving back-to-back operations.
- q_out and m_out are held stable throughout WAIT.
- q_out and m_out are not cleared after completion; they hold the last operands.
- mthi/mtlo:
  - Honoured only in IDLE. In IDLE, hi <= wdata on mthi and lo <= wdata on mtlo. Both asserted writes both.
  - Ignored during WAIT, so a move cannot corrupt an in-flight result.
  - mthi/mtlo together with start in IDLE: the move applies now, and the operation result overwrites it at completion.
- dz is sticky until the next accepted start.
- HI/LO contents on divide-by-zero are whatever z_in presents. With the team divider:
  - quotient = all ones, negated when the signs differ;
  - remainder = dividend.
- No arithmetic is performed here; widths pass through unchanged.

Test Plan:
- Reset mid-WAIT: start with 100/7, drop clr_n at cycle 2 -> busy=0, hi=lo=0, no done pulse, and the state is IDLE after release.
- Signed divide, LATENCY=4, divider attached: op_a=7, op_b=0xFFFFFFFE (-2), start at edge 0 -> busy high for cycles 1..4; done at edge 4 with lo=0xFFFFFFFD, hi=0x00000001, dz=0.
- Negative dividend: op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero:
  - 5/0 -> lo=0xFFFFFFFF, hi=5, dz=1.
  - Then 0xFFFFFFFB/0 -> lo=0x00000001, hi=0xFFFFFFFB, dz=1.
  - dz clears on the next start.
- Handshake:
  - Pulse start again at cycle 2 with different operands -> ignored, and the result matches the first operands.
  - Start in the done cycle -> the second operation completes LATENCY cycles later.
- Moves: in IDLE, mthi=mtlo=1 with wdata=0xA5A5A5A5 -> hi=lo=0xA5A5A5A5. The same moves during WAIT -> no effect, and the final hi/lo equal z_in.

Source files
------------

// File: rtl/hilo_seq.sv
// Multicycle sequencer around the combinational divider/multiplier: latches operands,
// waits LATENCY cycles for the unit to settle, then captures {remainder, quotient} into HI/LO.
module hilo_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 4
) (
   input  logic                    clk,
   input  logic                    clr_n,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   op_a,
   input  logic [DATA_WIDTH-1:0]   op_b,
   output logic [DATA_WIDTH-1:0]   q_out,
   output logic [DATA_WIDTH-1:0]   m_out,
   input  logic [2*DATA_WIDTH-1:0] z_in,
   input  logic                    mthi,
   input  logic                    mtlo,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   hi,
   output logic [DATA_WIDTH-1:0]   lo,
   output logic                    dz
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t     state;
   logic [3:0] cnt;

   function automatic logic is_zero(input logic [DATA_WIDTH-1:0] v);
      return (v == '0);
   endfunction

   assign busy = (state == WAIT);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= IDLE;
         cnt   <= '0;
         q_out <= '0;
         m_out <= '0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
         dz    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // Moves land first; a same-cycle start's result overwrites them at completion.
               if (mthi) hi <= wdata;
               if (mtlo) lo <= wdata;
               if (start) begin
                  q_out <= op_a;
                  m_out <= op_b;
                  cnt   <= CNT_INIT;
                  dz    <= 1'b0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  hi    <= z_in[2*DATA_WIDTH-1:DATA_WIDTH];
                  lo    <= z_in[DATA_WIDTH-1:0];
                  dz    <= is_zero(m_out);
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_seq.sv
// Bench for hilo_seq: directed scenarios plus random traffic against a completion-time model,
// with a behavioural signed divider attached to q_out/m_out.
module tb_hilo_seq;
   localparam int DW  = 32;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          clr_n = 1'b0;
   logic          start = 1'b0;
   logic          mthi = 1'b0;
   logic          mtlo = 1'b0;
   logic [DW-1:0] op_a = '0;
   logic [DW-1:0] op_b = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] q_out, m_out, hi, lo;
   logic [2*DW-1:0] z_in;
   logic          busy, done, dz;

   hilo_seq #(.DATA_WIDTH(DW), .LATENCY(LAT)) dut (
      .clk(clk), .clr_n(clr_n), .start(start), .op_a(op_a), .op_b(op_b),
      .q_out(q_out), .m_out(m_out), .z_in(z_in), .mthi(mthi), .mtlo(mtlo),
      .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
   );

   always #5 clk = ~clk;

   // Team divider behaviour: truncating signed divide; x/0 gives quotient -1 (or +1 for a
   // negative dividend) and remainder = dividend.
   function automatic logic [2*DW-1:0] div_unit(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [DW-1:0] sa, sb, q, r;
      sa = a;
      sb = b;
      if (b == '0) begin
         q = sa[DW-1] ? 32'sd1 : -32'sd1;
         r = sa;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = sa;
         r = '0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
      return {r, q};
   endfunction

   assign z_in = div_unit(q_out, m_out);

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          fin = 0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   bit          m_dz = 1'b0;
   logic [DW-1:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic check_all();
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("dz", 64'(dz), 64'(m_dz));
      chk("q_out", 64'(q_out), 64'(m_a));
      chk("m_out", 64'(m_out), 64'(m_b));
   endtask

   // Called at a falling edge: drive inputs, predict the next rising edge, then check.
   task automatic step(input bit st, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit mh, input bit ml, input logic [DW-1:0] wd);
      logic [2*DW-1:0] z;
      start = st; op_a = a; op_b = b; mthi = mh; mtlo = ml; wdata = wd;
      m_done = 1'b0;
      if (!m_busy) begin
         if (mh) m_hi = wd;
         if (ml) m_lo = wd;
         if (st) begin
            m_busy = 1'b1;
            m_a = a;
            m_b = b;
            m_dz = 1'b0;
            fin = cyc + LAT;
         end
      end else if (cyc == fin) begin
         z = div_unit(m_a, m_b);
         m_hi = z[2*DW-1:DW];
         m_lo = z[DW-1:0];
         m_dz = (m_b == '0);
         m_done = 1'b1;
         m_busy = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
      step(1'b1, a, b, 1'b0, 1'b0, '0);
      repeat (LAT) idle();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_all();
      clr_n = 1'b1;
      idle();

      // Reset during WAIT aborts the operation.
      step(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, '0);
      idle();
      #2 clr_n = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
      #1 check_all();
      @(negedge clk);
      clr_n = 1'b1;
      repeat (LAT + 1) idle();
      chk("abort_done", 64'(done), 64'd0);

      // Signed divides with busy profile checked every cycle by the model.
      run_op(32'd7, 32'hFFFF_FFFE);
      chk("d1_done", 64'(done), 64'd1);
      chk("d1_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("d1_hi", 64'(hi), 64'h0000_0001);
      chk("d1_dz", 64'(dz), 64'd0);
      run_op(32'hFFFF_FFF9, 32'd2);
      chk("d2_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("d2_hi", 64'(hi), 64'hFFFF_FFFF);

      // Divide by zero, then dz clears on the next start.
      run_op(32'd5, 32'd0);
      chk("z1_lo", 64'(lo), 64'hFFFF_FFFF);
      chk("z1_hi", 64'(hi), 64'd5);
      chk("z1_dz", 64'(dz), 64'd1);
      idle();
      chk("z1_sticky", 64'(dz), 64'd1);
      run_op(32'hFFFF_FFFB, 32'd0);
      chk("z2_lo", 64'(lo), 64'h0000_0001);
      chk("z2_hi", 64'(hi), 64'hFFFF_FFFB);
      chk("z2_dz", 64'(dz), 64'd1);
      idle();
      step(1'b1, 32'd9, 32'd3, 1'b0, 1'b0, '0);
      chk("dz_clear", 64'(dz), 64'd0);
      repeat (LAT) idle();

      // Start while busy is ignored.
      step(1'b1, 32'd20, 32'd3, 1'b0, 1'b0, '0);
      idle();
      step(1'b1, 32'd99, 32'd5, 1'b0, 1'b0, '0);
      repeat (LAT - 2) idle();
      chk("ign_lo", 64'(lo), 64'd6);
      chk("ign_hi", 64'(hi), 64'd2);

      // Back-to-back: start accepted in the done cycle.
      run_op(32'd40, 32'd6);
      chk("b2b_done1", 64'(done), 64'd1);
      run_op(32'd50, 32'd7);
      chk("b2b_done2", 64'(done), 64'd1);
      chk("b2b_lo", 64'(lo), 64'd7);
      chk("b2b_hi", 64'(hi), 64'd1);

      // Moves in IDLE, moves during WAIT, and a move coincident with start.
      step(1'b0, '0, '0, 1'b1, 1'b1, 32'hA5A5_A5A5);
      chk("mv_hi", 64'(hi), 64'hA5A5_A5A5);
      chk("mv_lo", 64'(lo), 64'hA5A5_A5A5);
      step(1'b1, 32'd11, 32'd4, 1'b1, 1'b1, 32'h1234_5678);
      chk("mvs_hi", 64'(hi), 64'h1234_5678);
      repeat (LAT - 1) step(1'b0, '0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      step(1'b0, '0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      chk("mvw_hi", 64'(hi), 64'd3);
      chk("mvw_lo", 64'(lo), 64'd2);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         logic [DW-1:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? '0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom);
         if ($urandom_range(0, 3) == 0) a = 32'($signed(-32'sd1) * $signed(32'($urandom_range(0, 100))));
         step(($urandom_range(0, 2) == 0), a, b, ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 4) == 0), $urandom);
      end
      repeat (LAT + 1) idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
